// File: rtl/fpga_reset_pkg.sv
// Shared types and constants for the FPGA board-reset conditioner.
// Holds the FSM state encoding seen on state_o and the shared-counter width helper.
package fpga_reset_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    DEBOUNCE = 2'd2
  } rst_state_e;

  localparam int unsigned PRESS_CNT_W = 8;

  // Width needed to count up to max(a,b)-1, never narrower than one bit.
  function automatic int unsigned cnt_width_f(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fpga_rst_sync.sv
// N-stage flop synchronizer for a single asynchronous level signal.
// Every stage resets to 0, so the synchronized value reads low until STAGES edges after release.
module fpga_rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fpga_reset_conditioner.sv
// Conditions the board reset for the SoC: synchronizes button and PLL lock, debounces the
// button, and stretches reset so pad_reset_n only ever sees a clean, clock-aligned pulse.
module fpga_reset_conditioner
  import fpga_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned CNT_WIDTH       = cnt_width_f(DEBOUNCE_CYCLES, HOLD_CYCLES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   btn_reset_ni,
  input  logic                   clk_locked_i,
  output logic                   rst_no,
  output logic [1:0]             state_o,
  output logic [PRESS_CNT_W-1:0] press_count_o
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   btn_sync;
  logic                   lock_sync;
  logic                   good;
  rst_state_e             state_q;
  rst_state_e             state_d;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   press_inc;
  logic                   rst_q;
  logic [PRESS_CNT_W-1:0] press_count_q;

  fpga_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_reset_ni),
    .q_o    (btn_sync)
  );

  fpga_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (clk_locked_i),
    .q_o    (lock_sync)
  );

  assign good = btn_sync & lock_sync;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt + CNT_WIDTH'(1);
    press_inc = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (!good) begin
          cnt_d = '0;
        end else if (cnt == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_sync) begin
          state_d = HOLD;
        end else if (!btn_sync) begin
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Lock loss outranks everything, so a press coinciding with it is never counted.
        if (!lock_sync) begin
          state_d = HOLD;
        end else if (btn_sync) begin
          state_d = RUN;
        end else if (cnt == DEB_LAST) begin
          state_d   = HOLD;
          press_inc = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // rst_no comes from next state so its release lines up with the RUN entry edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= HOLD;
      cnt           <= '0;
      rst_q         <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      rst_q   <= (state_d == RUN) || (state_d == DEBOUNCE);
      if (press_inc && (press_count_q != '1)) begin
        press_count_q <= press_count_q + PRESS_CNT_W'(1);
      end
    end
  end

  assign rst_no        = rst_q;
  assign state_o       = state_q;
  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_fpga_reset_conditioner.sv
// Directed bench for fpga_reset_conditioner with SYNC_STAGES=2, HOLD_CYCLES=16, DEBOUNCE_CYCLES=8.
// Inputs change 1 ns after a rising edge; edge 1 is the next rising edge after a change.
module tb_fpga_reset_conditioner;

  logic       clk_i;
  logic       rst_ni;
  logic       btn_reset_ni;
  logic       clk_locked_i;
  logic       rst_no;
  logic [1:0] state_o;
  logic [7:0] press_count_o;

  int vectors;
  int miscompares;

  fpga_reset_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .btn_reset_ni  (btn_reset_ni),
    .clk_locked_i  (clk_locked_i),
    .rst_no        (rst_no),
    .state_o       (state_o),
    .press_count_o (press_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Advance n edges, checking rst_no after every one of them.
  task automatic span(input string tag, input int n, input logic exp);
    for (int i = 0; i < n; i++) begin
      tick(1);
      check(tag, 32'(rst_no), 32'(exp));
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_ni       = 1'b0;
    btn_reset_ni = 1'b1;
    clk_locked_i = 1'b1;

    // Reset values while rst_ni is held.
    tick(3);
    check("rst_rst_no", 32'(rst_no), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_press", 32'(press_count_o), 0);
    check("rst_cnt", 32'(dut.cnt), 0);

    // Power-up: low through edge 17, high on edge 18.
    rst_ni = 1'b1;
    span("pwr_low", 17, 1'b0);
    check("pwr_state_hold", 32'(state_o), 0);
    tick(1);
    check("pwr_rise", 32'(rst_no), 1);
    check("pwr_state_run", 32'(state_o), 1);

    // Glitch of 5 synchronized cycles: DEBOUNCE seen, then back to RUN.
    btn_reset_ni = 1'b0;
    span("glitch5_rst", 5, 1'b1);
    check("glitch5_in_deb", 32'(state_o), 2);
    btn_reset_ni = 1'b1;
    span("glitch5_rst", 3, 1'b1);
    check("glitch5_back_run", 32'(state_o), 1);
    check("glitch5_press", 32'(press_count_o), 0);

    // Glitch of exactly DEBOUNCE_CYCLES synchronized cycles: still rejected.
    btn_reset_ni = 1'b0;
    span("glitch8_rst", 8, 1'b1);
    btn_reset_ni = 1'b1;
    span("glitch8_rst", 2, 1'b1);
    check("glitch8_in_deb", 32'(state_o), 2);
    span("glitch8_rst", 1, 1'b1);
    check("glitch8_back_run", 32'(state_o), 1);
    check("glitch8_press", 32'(press_count_o), 0);

    // Accepted press: rst_no falls on edge 11, then held low while button stays down.
    btn_reset_ni = 1'b0;
    span("press_high", 10, 1'b1);
    tick(1);
    check("press_fall", 32'(rst_no), 0);
    check("press_state", 32'(state_o), 0);
    check("press_count", 32'(press_count_o), 1);
    span("press_held", 19, 1'b0);
    check("press_held_cnt", 32'(dut.cnt), 0);
    btn_reset_ni = 1'b1;
    span("press_rel_low", 17, 1'b0);
    tick(1);
    check("press_rel_rise", 32'(rst_no), 1);
    check("press_rel_state", 32'(state_o), 1);

    // One-cycle lock drop: falls on edge 3, rises 18 edges after lock returns (edge 19).
    clk_locked_i = 1'b0;
    tick(1);
    check("lock_e1", 32'(rst_no), 1);
    clk_locked_i = 1'b1;
    tick(1);
    check("lock_e2", 32'(rst_no), 1);
    tick(1);
    check("lock_fall", 32'(rst_no), 0);
    check("lock_state", 32'(state_o), 0);
    span("lock_low", 15, 1'b0);
    tick(1);
    check("lock_rise", 32'(rst_no), 1);

    // Button and lock fall together in RUN, then button stays stuck low in HOLD.
    btn_reset_ni = 1'b0;
    clk_locked_i = 1'b0;
    tick(1);
    clk_locked_i = 1'b1;
    tick(2);
    check("both_fall", 32'(rst_no), 0);
    check("both_press", 32'(press_count_o), 1);
    span("stuck_low", 97, 1'b0);
    check("stuck_cnt", 32'(dut.cnt), 0);
    check("stuck_state", 32'(state_o), 0);
    btn_reset_ni = 1'b1;
    span("stuck_rel_low", 17, 1'b0);
    tick(1);
    check("stuck_rel_rise", 32'(rst_no), 1);
    check("stuck_press", 32'(press_count_o), 1);

    // Lock loss on the very edge the debounce would complete: press not counted.
    btn_reset_ni = 1'b0;
    span("coin_high", 8, 1'b1);
    clk_locked_i = 1'b0;
    tick(1);
    check("coin_e9", 32'(rst_no), 1);
    clk_locked_i = 1'b1;
    tick(1);
    check("coin_e10_state", 32'(state_o), 2);
    tick(1);
    check("coin_fall", 32'(rst_no), 0);
    check("coin_state", 32'(state_o), 0);
    check("coin_press", 32'(press_count_o), 1);
    btn_reset_ni = 1'b1;
    span("coin_rel_low", 17, 1'b0);
    tick(1);
    check("coin_rel_rise", 32'(rst_no), 1);

    // Asynchronous reset in the middle of DEBOUNCE, between clock edges.
    btn_reset_ni = 1'b0;
    tick(5);
    check("async_pre_state", 32'(state_o), 2);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_no", 32'(rst_no), 0);
    check("async_state", 32'(state_o), 0);
    check("async_press", 32'(press_count_o), 0);
    btn_reset_ni = 1'b1;
    tick(2);
    rst_ni = 1'b1;
    span("async_rel_low", 17, 1'b0);
    tick(1);
    check("async_rel_rise", 32'(rst_no), 1);

    // 256 accepted presses: counter stops at 255.
    for (int i = 0; i < 256; i++) begin
      btn_reset_ni = 1'b0;
      tick(11);
      btn_reset_ni = 1'b1;
      tick(18);
      if (i == 0) check("sat_first", 32'(press_count_o), 1);
      if (i == 254) check("sat_255", 32'(press_count_o), 255);
    end
    check("sat_hold", 32'(press_count_o), 255);
    check("sat_rst_no", 32'(rst_no), 1);
    check("sat_state", 32'(state_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
